// File: rtl/spi_mem_arbiter_pkg.sv
// Shared definitions for the SPI/camera RAM arbiter: FSM state encoding and
// default bus widths.
package spi_mem_arbiter_pkg;

    localparam int SPI_ADDR_W_DEF = 24;
    localparam int MEM_AW_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPI_WR  = 3'd1,
        ST_SPI_RD  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_CAM     = 3'd4
    } arb_state_t;

endpackage

// File: rtl/spi_mem_arbiter_edge_detect.sv
// Registered single-flag edge detector. RISE=1 reports 0->1, RISE=0 reports 1->0.
// The flag is already synchronous to main_clock, so one register is enough.
module arb_edge_detect #(
    parameter bit RISE = 1'b1
) (
    input  logic main_clock,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Previous value of the flag
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) d_q <= 1'b0;
        else          d_q <= d;
    end

    assign pulse = RISE ? (d & ~d_q) : (~d & d_q);

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbiter sharing one single-port RAM between the SPI memory slave (strict
// priority, auto-incrementing byte pointer) and the camera pixel writer.
// Optional build macro ARB_STATS_EN enables the saturating stall_count.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no RAM access; pick write > read > camera for next cycle
// ST_SPI_WR  | write wdata_q at ptr, ptr++
// ST_SPI_RD  | issue read at ptr, ptr++
// ST_RD_WAIT | wait out RAM latency, capture mem_rdata on the last cycle
// ST_CAM     | camera write, cam_gnt pulse
module spi_mem_arbiter
    import spi_mem_arbiter_pkg::*;
#(
    parameter int SPI_ADDR_W = SPI_ADDR_W_DEF,
    parameter int MEM_AW     = MEM_AW_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic                  main_clock,
    input  logic                  reset_n,
    input  logic [SPI_ADDR_W-1:0] spi_addr,
    input  logic                  spi_addr_valid,
    input  logic [7:0]            spi_write_data,
    input  logic                  spi_write_data_flag,
    input  logic                  spi_read_data_flag,
    output logic [7:0]            spi_read_data,
    input  logic                  spi_active,
    input  logic                  cam_req,
    input  logic [MEM_AW-1:0]     cam_addr,
    input  logic [7:0]            cam_wdata,
    output logic                  cam_gnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic [15:0]           stall_count
);

    arb_state_t        state, state_nxt;
    logic [MEM_AW-1:0] ptr;
    logic              rd_pend, wr_pend;
    logic [7:0]        wdata_q;
    logic [1:0]        lat_cnt;
    logic              av_rise, rd_rise, wr_rise, act_fall;
    logic              wr_req, rd_req, rd_done;
    logic              unused_addr_hi;

    // Only the low MEM_AW address bits select a RAM byte.
    assign unused_addr_hi = ^spi_addr[SPI_ADDR_W-1:MEM_AW];

    arb_edge_detect #(.RISE(1'b1)) u_av  (.main_clock(main_clock), .reset_n(reset_n), .d(spi_addr_valid),      .pulse(av_rise));
    arb_edge_detect #(.RISE(1'b1)) u_rd  (.main_clock(main_clock), .reset_n(reset_n), .d(spi_read_data_flag),  .pulse(rd_rise));
    arb_edge_detect #(.RISE(1'b1)) u_wr  (.main_clock(main_clock), .reset_n(reset_n), .d(spi_write_data_flag), .pulse(wr_rise));
    arb_edge_detect #(.RISE(1'b0)) u_act (.main_clock(main_clock), .reset_n(reset_n), .d(spi_active),          .pulse(act_fall));

    // A fresh rise counts as a request in the same cycle so SPI beats a
    // camera request that appears together with it; a CS drop kills both.
    assign wr_req  = (wr_pend | wr_rise) & ~act_fall;
    assign rd_req  = (rd_pend | rd_rise) & ~act_fall;
    assign rd_done = (state == ST_RD_WAIT) && (lat_cnt == 2'd0);

    // State register
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and RAM strobes
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cam_gnt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (wr_req)       state_nxt = ST_SPI_WR;
                else if (rd_req)  state_nxt = ST_SPI_RD;
                else if (cam_req) state_nxt = ST_CAM;
            end
            ST_SPI_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ptr;
                mem_wdata = wdata_q;
                state_nxt = ST_IDLE;
            end
            ST_SPI_RD: begin
                mem_en    = 1'b1;
                mem_addr  = ptr;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_cnt == 2'd0) state_nxt = ST_IDLE;
            end
            ST_CAM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cam_addr;
                mem_wdata = cam_wdata;
                cam_gnt   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointer, pending requests, latency down-counter and read capture
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            rd_pend       <= 1'b0;
            wr_pend       <= 1'b0;
            wdata_q       <= '0;
            lat_cnt       <= '0;
            spi_read_data <= '0;
        end else begin
            if (av_rise)
                ptr <= spi_addr[MEM_AW-1:0];
            else if (state == ST_SPI_WR || state == ST_SPI_RD)
                ptr <= ptr + 1'b1;

            // A rise while the bit is still set is a duplicate and is dropped.
            if (act_fall || state == ST_SPI_WR) begin
                wr_pend <= 1'b0;
            end else if (wr_rise && !wr_pend) begin
                wr_pend <= 1'b1;
                wdata_q <= spi_write_data;
            end

            if (act_fall || state == ST_SPI_RD) rd_pend <= 1'b0;
            else if (rd_rise)                   rd_pend <= 1'b1;

            if (state == ST_SPI_RD)
                lat_cnt <= 2'(RD_LATENCY - 1);
            else if (state == ST_RD_WAIT && lat_cnt != 2'd0)
                lat_cnt <= lat_cnt - 1'b1;

            // In-flight reads still land even after a CS abort.
            if (rd_done) spi_read_data <= mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    logic        rd_dup, wr_dup, cam_stall;
    logic [1:0]  stall_inc;
    logic [16:0] stall_sum;
    logic [15:0] stall_q;

    assign rd_dup    = rd_rise & rd_pend & ~act_fall;
    assign wr_dup    = wr_rise & wr_pend & ~act_fall;
    assign cam_stall = cam_req & ~cam_gnt;
    assign stall_inc = {1'b0, cam_stall} + {1'b0, rd_dup} + {1'b0, wr_dup};
    assign stall_sum = {1'b0, stall_q} + {15'b0, stall_inc};

    // Saturating stall / protocol-error counter
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
